// File: rtl/neopx_rx.sv
// neopx_rx: WS2812-style serial pixel decoder with a single-entry AXI-Stream output.
module neopx_rx #(
  parameter int unsigned BIT1_MIN_CYC = 40,
  parameter int unsigned HIGH_MAX_CYC = 100,
  parameter int unsigned RESET_CYC    = 2800
) (
  input  logic        axis_aclk,
  input  logic        axis_reset,
  input  logic        i_serial,
  output logic [31:0] m_axis_data,
  output logic        m_axis_valid,
  input  logic        m_axis_ready,
  output logic        o_frame_end,
  output logic        o_frame_err,
  output logic        o_overrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BCNT_W = 5;
  localparam int unsigned PIX_W  = 24;

  localparam logic [CNT_W-1:0]  BIT1_MIN  = CNT_W'(BIT1_MIN_CYC);
  localparam logic [CNT_W-1:0]  HIGH_MAX  = CNT_W'(HIGH_MAX_CYC);
  localparam logic [CNT_W-1:0]  LATCH_CNT = CNT_W'(RESET_CYC);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [BCNT_W-1:0] LAST_BIT  = BCNT_W'(PIX_W - 1);

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    IDLE = 2'd1,
    HIGH = 2'd2,
    LOW  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                sync2_q, sync2_d;
  logic                sdly_q, sdly_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [PIX_W-2:0]    shift_q, shift_d;
  logic [PIX_W-1:0]    data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_end_q, frame_end_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  logic                rise_c, fall_c, bit_c, pix_done_c;
  logic [CNT_W-1:0]    count_inc_c;
  logic [PIX_W-1:0]    pix_c;

  // State and datapath registers with synchronous reset
  always_ff @(posedge axis_aclk) begin
    if (axis_reset) begin
      state_q     <= SYNC;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sdly_q      <= 1'b0;
      count_q     <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sdly_q      <= sdly_d;
      count_q     <= count_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Synchronizer, edge detect, line-timing FSM and output register control
  always_comb begin
    sync1_d     = i_serial;
    sync2_d     = sync1_q;
    sdly_d      = sync2_q;
    state_d     = state_q;
    count_d     = count_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_end_d = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    pix_done_c  = 1'b0;

    rise_c      = sync2_q & ~sdly_q;
    fall_c      = ~sync2_q & sdly_q;
    count_inc_c = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
    bit_c       = (count_q >= BIT1_MIN);
    pix_c       = {shift_q, bit_c};

    unique case (state_q)
      SYNC: begin
        // Wait for one full latch gap before trusting the line
        if (sync2_q) begin
          count_d = '0;
        end else if (count_inc_c >= LATCH_CNT) begin
          count_d = '0;
          state_d = IDLE;
        end else begin
          count_d = count_inc_c;
        end
      end
      IDLE: begin
        if (rise_c) begin
          count_d  = CNT_W'(1);
          bitcnt_d = '0;
          state_d  = HIGH;
        end
      end
      HIGH: begin
        if (fall_c) begin
          count_d = CNT_W'(1);
          state_d = LOW;
          if (bitcnt_q == LAST_BIT) begin
            pix_done_c = 1'b1;
            bitcnt_d   = '0;
            shift_d    = '0;
          end else begin
            bitcnt_d = bitcnt_q + BCNT_W'(1);
            shift_d  = {shift_q[PIX_W-3:0], bit_c};
          end
        end else if (count_inc_c > HIGH_MAX) begin
          // Stuck-high line: drop everything and resynchronise
          frame_err_d = 1'b1;
          count_d     = '0;
          bitcnt_d    = '0;
          shift_d     = '0;
          state_d     = SYNC;
        end else begin
          count_d = count_inc_c;
        end
      end
      LOW: begin
        if (rise_c) begin
          count_d = CNT_W'(1);
          state_d = HIGH;
        end else if (count_inc_c >= LATCH_CNT) begin
          frame_end_d = 1'b1;
          frame_err_d = (bitcnt_q != '0);
          count_d     = '0;
          bitcnt_d    = '0;
          shift_d     = '0;
          state_d     = IDLE;
        end else begin
          count_d = count_inc_c;
        end
      end
      default: state_d = SYNC;
    endcase

    // Single-entry output: handshake frees the slot, a completed pixel
    // loads only if the slot is free this cycle, otherwise it is dropped
    if (valid_q && m_axis_ready) begin
      valid_d = 1'b0;
    end
    if (pix_done_c) begin
      if (!valid_q || m_axis_ready) begin
        data_d  = pix_c;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  assign m_axis_data  = {8'h00, data_q};
  assign m_axis_valid = valid_q;
  assign o_frame_end  = frame_end_q;
  assign o_frame_err  = frame_err_q;
  assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_neopx_rx.sv
// tb_neopx_rx: directed stimulus with a queue-based scoreboard for neopx_rx.
module tb_neopx_rx;

  logic        clk;
  logic        rst;
  logic        ser;
  logic [31:0] data;
  logic        valid;
  logic        ready;
  logic        fend;
  logic        ferr;
  logic        ovr;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fe_cnt  = 0;
  int fr_cnt  = 0;
  int both_cnt = 0;
  logic [31:0] exp_q[$];

  neopx_rx #(
    .BIT1_MIN_CYC(8),
    .HIGH_MAX_CYC(40),
    .RESET_CYC   (100)
  ) dut (
    .axis_aclk   (clk),
    .axis_reset  (rst),
    .i_serial    (ser),
    .m_axis_data (data),
    .m_axis_valid(valid),
    .m_axis_ready(ready),
    .o_frame_end (fend),
    .o_frame_err (ferr),
    .o_overrun   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: inputs change 2 time units after posedge, so negedge sees
  // exactly what the next rising edge will sample
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL beat_unexpected: got %08h, required no beat", data);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (data !== e) begin
            err_cnt++;
            $display("FAIL beat_data: got %08h, required %08h", data, e);
          end
        end
      end
      if (fend) fe_cnt++;
      if (ferr) fr_cnt++;
      if (fend && ferr) both_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    int hi;
    hi = b ? 12 : 4;
    ser = 1'b1;
    tick(hi);
    ser = 1'b0;
    tick(20 - hi);
  endtask

  task automatic send_bits(input logic [23:0] px, input int nbits);
    for (int i = 23; i > 23 - nbits; i--) send_bit(px[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ser = 1'b0;
    tick(3);
    rst = 1'b0;
  endtask

  int fe0, fr0, bo0;

  task automatic snap();
    fe0 = fe_cnt;
    fr0 = fr_cnt;
    bo0 = both_cnt;
  endtask

  initial begin
    rst = 1'b1;
    ser = 1'b0;
    ready = 1'b1;
    tick(3);
    // Reset state
    chk("rst_valid", {31'b0, valid}, 32'h0);
    chk("rst_data", data, 32'h0);
    chk("rst_fend", {31'b0, fend}, 32'h0);
    chk("rst_ferr", {31'b0, ferr}, 32'h0);
    chk("rst_ovr", {31'b0, ovr}, 32'h0);
    rst = 1'b0;

    // Basic pixel and clean latch
    snap();
    tick(120);
    exp_q.push_back(32'h00A5C33C);
    send_bits(24'hA5C33C, 24);
    tick(120);
    chk("t1_fend", 32'(fe_cnt - fe0), 32'd1);
    chk("t1_ferr", 32'(fr_cnt - fr0), 32'd0);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // Back-to-back pixels with ready low: first held, rest dropped
    ready = 1'b0;
    send_bits(24'h000001, 24);
    send_bits(24'h800000, 24);
    send_bits(24'hFFFFFF, 24);
    tick(120);
    chk("t2_valid", {31'b0, valid}, 32'h1);
    chk("t2_held", data, 32'h00000001);
    chk("t2_ovr", {31'b0, ovr}, 32'h1);
    exp_q.push_back(32'h00000001);
    ready = 1'b1;
    tick(5);
    chk("t2_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_valid_clr", {31'b0, valid}, 32'h0);
    chk("t2_ovr_sticky", {31'b0, ovr}, 32'h1);

    // Partial pixel then latch: end and error together, no beat
    snap();
    send_bits(24'h3FF000, 10);
    tick(120);
    chk("t3_fend", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_ferr", 32'(fr_cnt - fr0), 32'd1);
    chk("t3_both", 32'(both_cnt - bo0), 32'd1);
    exp_q.push_back(32'h00123456);
    send_bits(24'h123456, 24);
    tick(120);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Stuck high mid-pixel, then traffic ignored until a full latch gap
    snap();
    send_bits(24'hF0F0F0, 5);
    ser = 1'b1;
    tick(50);
    ser = 1'b0;
    tick(10);
    send_bits(24'hDEADBE, 24);
    tick(120);
    chk("t4_ferr", 32'(fr_cnt - fr0), 32'd1);
    chk("t4_fend_none", 32'(fe_cnt - fe0), 32'd0);
    exp_q.push_back(32'h000F0F0F);
    send_bits(24'h0F0F0F, 24);
    tick(120);
    chk("t4_fend", 32'(fe_cnt - fe0), 32'd1);
    chk("t4_q_empty", 32'(exp_q.size()), 32'd0);

    // After reset, traffic without a preceding latch gap is ignored
    do_reset();
    chk("t5_ovr_clr", {31'b0, ovr}, 32'h0);
    snap();
    send_bits(24'hAAAAAA, 24);
    tick(120);
    chk("t5_fend_none", 32'(fe_cnt - fe0), 32'd0);
    exp_q.push_back(32'h00555555);
    send_bits(24'h555555, 24);
    tick(120);
    chk("t5_fend", 32'(fe_cnt - fe0), 32'd1);
    chk("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-pixel with a held pixel: everything lost
    ready = 1'b0;
    send_bits(24'h112233, 24);
    tick(30);
    chk("t6_held_valid", {31'b0, valid}, 32'h1);
    send_bits(24'h445566, 15);
    ser = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(1);
    chk("t6_valid", {31'b0, valid}, 32'h0);
    chk("t6_data", data, 32'h0);
    chk("t6_fend", {31'b0, fend}, 32'h0);
    chk("t6_ferr", {31'b0, ferr}, 32'h0);
    chk("t6_ovr", {31'b0, ovr}, 32'h0);
    ser = 1'b0;
    tick(2);
    rst = 1'b0;
    ready = 1'b1;
    tick(120);
    exp_q.push_back(32'h00C0FFEE);
    send_bits(24'hC0FFEE, 24);
    tick(120);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
